// File: rtl/mm_pkg.sv
// Shared matrix-multiply definitions: drain FSM states and default PE datapath widths.
package mm_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 16;
  localparam int unsigned ACCUM_WIDTH_DEF = 33;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_DONE,
    DRAIN
  } drain_state_t;

endpackage

// File: rtl/pe_result_drain_acc_narrow.sv
// Narrows one PE total to OUT_WIDTH. PE_DRAIN_SATURATE_EN selects clamping (with sat flag);
// otherwise the total is truncated (two's-complement wrap) and sat is always 0.
module acc_narrow
  import mm_pkg::*;
#(
  parameter int unsigned ACCUM_WIDTH = ACCUM_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH   = ACCUM_WIDTH
) (
  input  logic signed [ACCUM_WIDTH-1:0] total,
  output logic signed [OUT_WIDTH-1:0]   narrow,
  output logic                          sat
);

  // Bits that must all match the sign for the value to fit in OUT_WIDTH.
  logic [ACCUM_WIDTH-OUT_WIDTH:0] hi;
  assign hi = total[ACCUM_WIDTH-1:OUT_WIDTH-1];

`ifdef PE_DRAIN_SATURATE_EN
  logic fits;
  assign fits = (&hi) | (~|hi);

  always_comb begin
    narrow = total[OUT_WIDTH-1:0];
    sat    = 1'b0;
    if (!fits) begin
      sat    = 1'b1;
      narrow = total[ACCUM_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  logic hi_unused;
  assign hi_unused = ^hi;
  assign narrow    = total[OUT_WIDTH-1:0];
  assign sat       = 1'b0;
`endif

endmodule

// File: rtl/pe_result_drain.sv
// Captures one total per PE at the end of a pass and streams them out on valid/ready.
// Optional clamping of narrowed totals is enabled by PE_DRAIN_SATURATE_EN.
module pe_result_drain
  import mm_pkg::*;
#(
  parameter int unsigned NUM_PE      = 8,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned ACCUM_WIDTH = 2 * DATA_WIDTH + 1,
  parameter int unsigned OUT_WIDTH   = ACCUM_WIDTH,
  localparam int unsigned IDX_WIDTH  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    pass_start,
  input  logic [NUM_PE-1:0]                       pe_ready,
  input  logic [NUM_PE-1:0][ACCUM_WIDTH-1:0]      pe_total,
  input  logic [NUM_PE-1:0]                       pe_err,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [OUT_WIDTH-1:0]             out_data,
  output logic [IDX_WIDTH-1:0]                    out_idx,
  output logic                                    out_err,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    overrun
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_PE - 1);

  drain_state_t state_q, state_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic signed [OUT_WIDTH-1:0]  data_q [NUM_PE];
  logic signed [OUT_WIDTH-1:0]  data_d [NUM_PE];
  logic [NUM_PE-1:0]            err_q, err_d;
  logic                         overrun_q, overrun_d;

  logic signed [OUT_WIDTH-1:0]  narrow [NUM_PE];
  logic [NUM_PE-1:0]            sat;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_narrow
    acc_narrow #(
      .ACCUM_WIDTH(ACCUM_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
    ) u_acc_narrow (
      .total (pe_total[g]),
      .narrow(narrow[g]),
      .sat   (sat[g])
    );
  end

  logic handshake;
  assign handshake = (state_q == DRAIN) && out_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    err_d     = err_q;
    overrun_d = overrun_q | (pass_start && (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (pass_start) state_d = ARMED;
      end
      ARMED: begin
        if (~|pe_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (&pe_ready) begin
          for (int i = 0; i < NUM_PE; i++) begin
            data_d[i] = narrow[i];
          end
          err_d   = pe_err | sat;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Buffer is a shift register so the head entry drives the outputs directly.
        if (handshake) begin
          for (int i = 0; i < NUM_PE - 1; i++) begin
            data_d[i] = data_q[i+1];
          end
          data_d[NUM_PE-1] = '0;
          err_d            = err_q >> 1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign out_data  = data_q[0];
  assign out_idx   = idx_q;
  assign out_err   = err_q[0];
  assign out_last  = (state_q == DRAIN) && (idx_q == LastIdx);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: full-width instance plus a 16-bit output instance.
module tb_pe_result_drain;

  localparam int NP = 4;
  localparam int AW = 33;

  logic clk = 1'b0;
  logic rst;
  logic pass_start;
  logic [NP-1:0] pe_ready;
  logic [NP-1:0][AW-1:0] pe_total;
  logic [NP-1:0] pe_err;
  logic out_ready;

  logic               out_valid, out_err, out_last, busy, overrun;
  logic signed [32:0] out_data;
  logic [1:0]         out_idx;

  logic               n_valid, n_err, n_last, n_busy, n_overrun;
  logic signed [15:0] n_data;
  logic [1:0]         n_idx;

  always #5 clk = ~clk;

  pe_result_drain #(
    .NUM_PE    (NP),
    .DATA_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pass_start(pass_start),
    .pe_ready  (pe_ready),
    .pe_total  (pe_total),
    .pe_err    (pe_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  pe_result_drain #(
    .NUM_PE    (NP),
    .DATA_WIDTH(16),
    .OUT_WIDTH (16)
  ) dut_n (
    .clk       (clk),
    .rst       (rst),
    .pass_start(pass_start),
    .pe_ready  (pe_ready),
    .pe_total  (pe_total),
    .pe_err    (pe_err),
    .out_valid (n_valid),
    .out_ready (out_ready),
    .out_data  (n_data),
    .out_idx   (n_idx),
    .out_err   (n_err),
    .out_last  (n_last),
    .busy      (n_busy),
    .overrun   (n_overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  longint exp_data [NP];
  bit     exp_err  [NP];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a pass and walk the PE ready handshake until the block is draining.
  task automatic run_pass(input longint t0, input longint t1, input longint t2,
                          input longint t3, input logic [NP-1:0] errs);
    pe_total[0] = AW'(t0);
    pe_total[1] = AW'(t1);
    pe_total[2] = AW'(t2);
    pe_total[3] = AW'(t3);
    pe_err      = errs;
    pass_start  = 1'b1;
    pe_ready    = '1;
    step();
    check("armed_busy", busy, 1);
    pass_start = 1'b0;
    pe_ready   = '0;
    step();
    check("wait_valid", out_valid, 0);
    pe_ready = '1;
    step();
  endtask

  // Drain all beats with a repeating ready pattern; optionally pulse pass_start at one cycle.
  task automatic drain(input bit sel, input logic [7:0] rdy_pat, input int start_at);
    int beat = 0;
    int cyc  = 0;
    longint v, d, ix, e, l;
    while (beat < NP && cyc < 40) begin
      out_ready  = rdy_pat[cyc % 8];
      pass_start = (cyc == start_at);
      v  = sel ? n_valid : out_valid;
      d  = sel ? longint'(n_data) : longint'(out_data);
      ix = sel ? n_idx : out_idx;
      e  = sel ? n_err : out_err;
      l  = sel ? n_last : out_last;
      check("valid", v, 1);
      if (v == 1) begin
        check("data", d, exp_data[beat]);
        check("idx", ix, beat);
        check("err", e, longint'(exp_err[beat]));
        check("last", l, (beat == NP - 1) ? 1 : 0);
      end
      if (out_ready) beat++;
      step();
      cyc++;
    end
    pass_start = 1'b0;
    out_ready  = 1'b0;
    check("beats_delivered", beat, NP);
    check("valid_after", sel ? n_valid : out_valid, 0);
    check("busy_after", sel ? n_busy : busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    pass_start = 1'b0;
    pe_ready   = '1;
    pe_total   = '0;
    pe_err     = '0;
    out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);

    // Basic pass, full throughput.
    exp_data = '{5, -3, 100, 0};
    exp_err  = '{0, 0, 0, 0};
    run_pass(5, -3, 100, 0, 4'b0000);
    drain(1'b0, 8'hFF, -1);
    check("basic_overrun", overrun, 0);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    run_pass(5, -3, 100, 0, 4'b0000);
    drain(1'b0, 8'b1001_1001, -1);

    // Error passthrough on PE 1 only.
    exp_err = '{0, 1, 0, 0};
    run_pass(5, -3, 100, 0, 4'b0010);
    drain(1'b0, 8'hFF, -1);

    // Overrun: pass_start mid-drain is ignored but sticky-flagged.
    exp_err = '{0, 0, 0, 0};
    run_pass(7, 8, -9, 10, 4'b0000);
    exp_data = '{7, 8, -9, 10};
    drain(1'b0, 8'b1111_1101, 1);
    check("overrun_set", overrun, 1);
    step();
    step();
    check("overrun_idle_busy", busy, 0);
    check("overrun_sticky", overrun, 1);

    // Narrowed 16-bit instance.
`ifdef PE_DRAIN_SATURATE_EN
    exp_data = '{32767, -32768, 1234, -1};
    exp_err  = '{1, 1, 0, 0};
`else
    exp_data = '{-25536, 25536, 1234, -1};
    exp_err  = '{0, 0, 0, 0};
`endif
    run_pass(40000, -40000, 1234, -1, 4'b0000);
    drain(1'b1, 8'hFF, -1);

    // Reset while draining at idx 2.
    run_pass(1, 2, 3, 4, 4'b0000);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("mid_idx", out_idx, 2);
    check("mid_data", out_data, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_overrun", overrun, 0);
    check("mrst_idx", out_idx, 0);
    check("mrst_data", out_data, 0);
    step();
    check("mrst_stay_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
